nv_nvdla_sdp_core_c_chn_in_mwait_ctrl: RTL and testbench

Parametrised multi-channel successor to the SDP core input-channel wait controller. For each of NUM_CHN input channels it tracks a pending core read across stall cycles, generates input and done handshake strobes, and captures accepted data in a one-entry holding register. It also counts wait cycles per channel, flags timeouts, and reports a join condition when every selected channel holds data. It sits between the SDP core datapath and its input-channel ready/valid interfaces.

---
 rtl/nv_nvdla_sdp_core_c_chn_in_mwait_ctrl.sv | 96 +++++++++
 tb/tb_nv_nvdla_sdp_core_c_chn_in_mwait_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/nv_nvdla_sdp_core_c_chn_in_mwait_ctrl.sv
// Multi-channel SDP core input wait controller: per-channel pending-read tracking,
// one-entry holding register, saturating wait counter with timeout, and a join flag.
module nv_nvdla_sdp_core_c_chn_in_mwait_ctrl #(
    parameter int NUM_CHN = 4,
    parameter int DATA_W  = 32,
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 100,
    parameter int BYPASS  = 0
) (
    input  logic                        nvdla_core_clk,
    input  logic                        nvdla_core_rstn,
    input  logic                        core_wen,
    input  logic                        core_wten,
    input  logic [NUM_CHN-1:0]          chn_iswt0,
    input  logic [NUM_CHN-1:0]          chn_oswt,
    input  logic [NUM_CHN-1:0]          chn_ld_core_psct,
    input  logic [NUM_CHN-1:0]          chn_vd,
    input  logic [NUM_CHN*DATA_W-1:0]   chn_dat_in,
    input  logic [NUM_CHN-1:0]          chn_join_mask,
    output logic [NUM_CHN-1:0]          chn_biwt,
    output logic [NUM_CHN-1:0]          chn_bdwt,
    output logic [NUM_CHN-1:0]          chn_ld_core_sct,
    output logic [NUM_CHN*DATA_W-1:0]   chn_dat_out,
    output logic [NUM_CHN-1:0]          chn_dat_vld,
    output logic [NUM_CHN*CNT_W-1:0]    chn_wait_cnt,
    output logic [NUM_CHN-1:0]          chn_timeout,
    output logic                        all_done
);

    localparam longint unsigned CNT_MAX = (64'd1 << CNT_W) - 64'd1;
    // A threshold the counter can never reach simply disables the timeout.
    localparam bit              TO_EN   = (TIMEOUT != 0) && (64'(TIMEOUT) <= CNT_MAX);
    localparam logic [CNT_W-1:0] TO_VAL = TO_EN ? CNT_W'(TIMEOUT) : '0;
    localparam bit              BYP     = (BYPASS != 0);

    for (genvar c = 0; c < NUM_CHN; c++) begin : g_chn
        logic [DATA_W-1:0] dat_in_c;
        logic [DATA_W-1:0] dat_q, dat_d;
        logic [CNT_W-1:0]  cnt_q, cnt_d;
        logic              icwt_q, icwt_d;
        logic              vld_q, vld_d;
        logic              pdswt0, ogwt, biwt, bdwt;

        assign dat_in_c = chn_dat_in[c*DATA_W +: DATA_W];

        // Strobes are gated by reset so every output is quiet while reset is held.
        always_comb begin
            pdswt0 = chn_iswt0[c] & ~core_wten;
            ogwt   = (pdswt0 | icwt_q) & nvdla_core_rstn;
            biwt   = ogwt & chn_vd[c];
            bdwt   = chn_oswt[c] & core_wen & nvdla_core_rstn;
            icwt_d = ogwt & ~biwt;

            dat_d = dat_q;
            vld_d = vld_q;
            if (biwt) begin
                dat_d = dat_in_c;
                vld_d = 1'b1;
            end else if (bdwt) begin
                vld_d = 1'b0;
            end

            cnt_d = cnt_q;
            if (biwt || !ogwt) begin
                cnt_d = '0;
            end else if (icwt_q && !chn_vd[c] && (cnt_q != '1)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
            if (!nvdla_core_rstn) begin
                icwt_q <= 1'b0;
                vld_q  <= 1'b0;
                cnt_q  <= '0;
                dat_q  <= '0;
            end else begin
                icwt_q <= icwt_d;
                vld_q  <= vld_d;
                cnt_q  <= cnt_d;
                dat_q  <= dat_d;
            end
        end

        assign chn_biwt[c]                       = biwt;
        assign chn_bdwt[c]                       = bdwt;
        assign chn_ld_core_sct[c]                = chn_ld_core_psct[c] & ogwt;
        assign chn_wait_cnt[c*CNT_W +: CNT_W]    = cnt_q;
        assign chn_timeout[c]                    = TO_EN & icwt_q & (cnt_q >= TO_VAL);
        assign chn_dat_out[c*DATA_W +: DATA_W]   = (BYP && biwt) ? dat_in_c : dat_q;
        assign chn_dat_vld[c]                    = vld_q | (BYP & biwt);
    end

    assign all_done = (|chn_join_mask) & (&(chn_dat_vld | ~chn_join_mask));

endmodule

// File: tb/tb_nv_nvdla_sdp_core_c_chn_in_mwait_ctrl.sv
// Bench: two configurations (default, and CNT_W=2/TIMEOUT=3/BYPASS=1) share one
// stimulus stream and are compared every cycle against a behavioural model.
module tb_nv_nvdla_sdp_core_c_chn_in_mwait_ctrl;
    localparam int N  = 4;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic wen, wten;
    logic [N-1:0] iswt0, oswt, psct, vd, mask;
    logic [N*DW-1:0] din;

    logic [N-1:0] biwt_a, bdwt_a, sct_a, vld_a, to_a;
    logic [N*DW-1:0] dout_a;
    logic [N*8-1:0] cnt_a;
    logic done_a;
    logic [N-1:0] biwt_b, bdwt_b, sct_b, vld_b, to_b;
    logic [N*DW-1:0] dout_b;
    logic [N*2-1:0] cnt_b;
    logic done_b;

    nv_nvdla_sdp_core_c_chn_in_mwait_ctrl #(
        .NUM_CHN(N), .DATA_W(DW), .CNT_W(8), .TIMEOUT(100), .BYPASS(0)
    ) dut_a (
        .nvdla_core_clk(clk), .nvdla_core_rstn(rst_n), .core_wen(wen), .core_wten(wten),
        .chn_iswt0(iswt0), .chn_oswt(oswt), .chn_ld_core_psct(psct), .chn_vd(vd),
        .chn_dat_in(din), .chn_join_mask(mask), .chn_biwt(biwt_a), .chn_bdwt(bdwt_a),
        .chn_ld_core_sct(sct_a), .chn_dat_out(dout_a), .chn_dat_vld(vld_a),
        .chn_wait_cnt(cnt_a), .chn_timeout(to_a), .all_done(done_a)
    );

    nv_nvdla_sdp_core_c_chn_in_mwait_ctrl #(
        .NUM_CHN(N), .DATA_W(DW), .CNT_W(2), .TIMEOUT(3), .BYPASS(1)
    ) dut_b (
        .nvdla_core_clk(clk), .nvdla_core_rstn(rst_n), .core_wen(wen), .core_wten(wten),
        .chn_iswt0(iswt0), .chn_oswt(oswt), .chn_ld_core_psct(psct), .chn_vd(vd),
        .chn_dat_in(din), .chn_join_mask(mask), .chn_biwt(biwt_b), .chn_bdwt(bdwt_b),
        .chn_ld_core_sct(sct_b), .chn_dat_out(dout_b), .chn_dat_vld(vld_b),
        .chn_wait_cnt(cnt_b), .chn_timeout(to_b), .all_done(done_b)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state per configuration k and channel c.
    bit             pend [2][N];
    bit             hv   [2][N];
    logic [DW-1:0]  hd   [2][N];
    int             wc   [2][N];
    int cmax [2] = '{255, 3};
    int to_p [2] = '{100, 3};
    int byp  [2] = '{0, 1};
    int cw   [2] = '{8, 2};

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic expect_outs(input int k,
                               output logic [N-1:0] eb, output logic [N-1:0] ed,
                               output logic [N-1:0] es, output logic [N-1:0] ev,
                               output logic [N-1:0] et, output logic [127:0] eo,
                               output logic [127:0] ec, output logic ea);
        eb = '0; ed = '0; es = '0; ev = '0; et = '0; eo = '0; ec = '0; ea = 1'b0;
        for (int c = 0; c < N; c++) begin
            bit rq, ac;
            rq = rst_n && ((iswt0[c] && !wten) || pend[k][c]);
            ac = rq && vd[c];
            eb[c] = ac;
            ed[c] = rst_n && oswt[c] && wen;
            es[c] = rst_n && psct[c] && rq;
            ev[c] = hv[k][c] || (byp[k] != 0 && ac);
            eo[c*DW +: DW] = (byp[k] != 0 && ac) ? din[c*DW +: DW] : hd[k][c];
            ec = ec | (128'(wc[k][c]) << (c * cw[k]));
            et[c] = (to_p[k] != 0) && pend[k][c] && (wc[k][c] >= to_p[k]);
        end
        ea = (mask != '0);
        for (int c = 0; c < N; c++)
            if (mask[c] && !ev[c]) ea = 1'b0;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++)
                for (int c = 0; c < N; c++) begin
                    pend[k][c] = 0; hv[k][c] = 0; hd[k][c] = '0; wc[k][c] = 0;
                end
        end else begin
            for (int k = 0; k < 2; k++)
                for (int c = 0; c < N; c++) begin
                    bit rq, ac, dn;
                    rq = (iswt0[c] && !wten) || pend[k][c];
                    ac = rq && vd[c];
                    dn = oswt[c] && wen;
                    if (ac) begin
                        hd[k][c] = din[c*DW +: DW];
                        hv[k][c] = 1;
                    end else if (dn) begin
                        hv[k][c] = 0;
                    end
                    if (ac || !rq) wc[k][c] = 0;
                    else if (pend[k][c] && !vd[c]) wc[k][c] = (wc[k][c] + 1 > cmax[k]) ? cmax[k] : wc[k][c] + 1;
                    pend[k][c] = rq && !ac;
                end
        end
    end

    always @(negedge clk) begin
        logic [N-1:0] eb, ed, es, ev, et;
        logic [127:0] eo, ec;
        logic ea;
        expect_outs(0, eb, ed, es, ev, et, eo, ec, ea);
        chk("a_biwt", 128'(biwt_a), 128'(eb));
        chk("a_bdwt", 128'(bdwt_a), 128'(ed));
        chk("a_sct",  128'(sct_a),  128'(es));
        chk("a_vld",  128'(vld_a),  128'(ev));
        chk("a_to",   128'(to_a),   128'(et));
        chk("a_dout", 128'(dout_a), eo);
        chk("a_cnt",  128'(cnt_a),  ec);
        chk("a_done", 128'(done_a), 128'(ea));
        expect_outs(1, eb, ed, es, ev, et, eo, ec, ea);
        chk("b_biwt", 128'(biwt_b), 128'(eb));
        chk("b_bdwt", 128'(bdwt_b), 128'(ed));
        chk("b_sct",  128'(sct_b),  128'(es));
        chk("b_vld",  128'(vld_b),  128'(ev));
        chk("b_to",   128'(to_b),   128'(et));
        chk("b_dout", 128'(dout_b), eo);
        chk("b_cnt",  128'(cnt_b),  ec);
        chk("b_done", 128'(done_b), 128'(ea));
    end

    task automatic idle();
        wen = 0; wten = 0; iswt0 = '0; oswt = '0; psct = '0; vd = '0; mask = '0; din = '0;
    endtask

    task automatic rand_inputs(input bit starve);
        wen   = 1'($urandom_range(0, 1));
        wten  = ($urandom_range(0, 3) == 0);
        iswt0 = 4'($urandom);
        oswt  = 4'($urandom) & 4'($urandom);
        psct  = 4'($urandom);
        vd    = starve ? 4'b0000 : (4'($urandom) & 4'($urandom));
        mask  = 4'($urandom);
        for (int c = 0; c < N; c++) din[c*DW +: DW] = $urandom;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        rst_n = 0;
        repeat (3) begin
            rand_inputs(0);
            @(negedge clk);
            chk("rst_biwt_a", 128'(biwt_a), 128'(0));
            chk("rst_dvld_b", 128'(vld_b), 128'(0));
            cyc();
        end
        rst_n = 1;
        idle();
        @(negedge clk);
        chk("idle_done", 128'(done_a), 128'(0));

        // immediate accept on channel 0
        cyc(); idle(); iswt0 = 4'b0001; vd = 4'b0001; din[31:0] = 32'hA5A5A5A5;
        @(negedge clk);
        chk("imm_biwt0", 128'(biwt_a[0]), 128'(1));
        cyc(); idle();
        @(negedge clk);
        chk("imm_dout0", 128'(dout_a[31:0]), 128'h A5A5A5A5);
        chk("imm_vld0", 128'(vld_a[0]), 128'(1));

        // stall on channel 1: counter runs, saturates in dut_b, timeout there
        cyc(); idle(); iswt0 = 4'b0010;
        @(negedge clk);
        for (int i = 1; i <= 10; i++) begin
            cyc(); idle();
            if (i == 10) psct = 4'b0010;
            @(negedge clk);
        end
        chk("stall_cnt_a", 128'(cnt_a[15:8]), 128'(9));
        chk("stall_cnt_b", 128'(cnt_b[3:2]), 128'(3));
        chk("stall_to_b", 128'(to_b[1]), 128'(1));
        chk("stall_to_a", 128'(to_a[1]), 128'(0));
        chk("stall_sct", 128'(sct_a[1]), 128'(1));
        cyc(); idle(); vd = 4'b0010; din[63:32] = 32'h0000_1234;
        @(negedge clk);
        chk("arr_biwt1", 128'(biwt_a[1]), 128'(1));
        cyc(); idle();
        @(negedge clk);
        chk("arr_cnt_a", 128'(cnt_a[15:8]), 128'(0));
        chk("arr_to_b", 128'(to_b[1]), 128'(0));
        chk("arr_dout1", 128'(dout_a[63:32]), 128'h1234);

        // load and consume together: load wins
        cyc(); idle(); iswt0 = 4'b0010; vd = 4'b0010; oswt = 4'b0010; wen = 1; din[63:32] = 32'h0000_5678;
        @(negedge clk);
        chk("lc_bdwt1", 128'(bdwt_a[1]), 128'(1));
        cyc(); idle(); oswt = 4'b0010; wen = 1;
        @(negedge clk);
        chk("lc_vld1", 128'(vld_a[1]), 128'(1));
        chk("lc_dout1", 128'(dout_a[63:32]), 128'h5678);
        cyc(); idle();
        @(negedge clk);
        chk("cons_vld1", 128'(vld_a[1]), 128'(0));

        // join: ch0 held, ch2 accepting now (forwarded only in dut_b)
        cyc(); idle(); mask = 4'b0101; iswt0 = 4'b0100; vd = 4'b0100;
        @(negedge clk);
        chk("join_b", 128'(done_b), 128'(1));
        chk("join_a", 128'(done_a), 128'(0));
        cyc(); idle(); mask = 4'b0000;
        @(negedge clk);
        chk("join_empty", 128'(done_b), 128'(0));
        cyc(); idle(); mask = 4'b0101;
        @(negedge clk);
        chk("join_a_held", 128'(done_a), 128'(1));

        // reset mid-wait on channel 3
        cyc(); idle(); iswt0 = 4'b1000;
        repeat (3) begin cyc(); idle(); psct = 4'b1000; end
        @(negedge clk);
        chk("mw_cnt3", 128'(cnt_a[31:24]), 128'(2));
        @(posedge clk);
        #3 rst_n = 0;
        #1;
        chk("mw_rst_cnt", 128'(cnt_a), 128'(0));
        chk("mw_rst_vld", 128'(vld_a), 128'(0));
        chk("mw_rst_to", 128'(to_b), 128'(0));
        cyc(); rst_n = 1;

        // random phase with starvation windows and occasional async reset
        for (int i = 0; i < 3000; i++) begin
            cyc();
            if (!rst_n) rst_n = 1;
            rand_inputs((i % 600) >= 450 && (i % 600) < 580);
            if (i % 700 == 699) #2 rst_n = 0;
        end
        cyc();
        idle();
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
